block_cnt_frame_stats: RTL and testbench

//  Downstream consumer of the per-word bit-block counter. Accepts one 4-bit block count per

---
 rtl/blk_stat_pkg.sv | 22 ++
 rtl/blk_stat_outreg.sv | 60 ++++++
 rtl/block_cnt_frame_stats.sv | 125 ++++++++++++
 tb/tb_block_cnt_frame_stats.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blk_stat_pkg.sv
// Shared types and helpers for the per-frame block-count statistics datapath.
package blk_stat_pkg;

   localparam int unsigned BLK_CNT_W = 4;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACC  = 1'b1
   } state_e;

   // Saturating add of a block count onto a sum that is w bits wide (w <= 63).
   function automatic logic [63:0] sat_add(input logic [63:0]          sum,
                                           input logic [BLK_CNT_W-1:0] cnt,
                                           input int unsigned          w);
      logic [63:0] lim;
      logic [63:0] s;
      lim = (64'd1 << w) - 64'd1;
      s   = sum + 64'(cnt);
      return (s > lim) ? lim : s;
   endfunction

endpackage

// File: rtl/blk_stat_outreg.sv
// One-deep valid/ready holding register; a load while full and not draining is
// dropped and flagged on the sticky ovf bit.
module blk_stat_outreg
   import blk_stat_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ovf_clr,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         ovf
);

   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;
   logic         ovf_q, ovf_d;
   logic         handshake;
   logic         accept;

   always_comb begin
      handshake = valid_q && out_ready;
      accept    = load && (!valid_q || out_ready);
      data_d    = data_q;
      valid_d   = valid_q;
      ovf_d     = ovf_q;
      if (accept) begin
         data_d  = load_data;
         valid_d = 1'b1;
      end else if (handshake) begin
         valid_d = 1'b0;
      end
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end else if (load && !accept) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign ovf       = ovf_q;

endmodule

// File: rtl/block_cnt_frame_stats.sv
// Groups FRAME_LEN valid block counts into a frame and emits sum/max/min/zero-count
// through a stallable valid/ready output register.
module block_cnt_frame_stats
   import blk_stat_pkg::*;
#(
   parameter int FF_DLY    = 1,
   parameter int FRAME_LEN = 16,
   parameter int SUM_W     = 12,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BLK_CNT_W-1:0] block_cnt,
   input  logic                 valid,
   input  logic                 frame_clr,
   output logic [SUM_W-1:0]     frm_sum,
   output logic [BLK_CNT_W-1:0] frm_max,
   output logic [BLK_CNT_W-1:0] frm_min,
   output logic [CNT_W-1:0]     frm_zero,
   output logic                 frm_valid,
   input  logic                 frm_ready,
   output logic                 ovf
);

   localparam int unsigned PAY_W = SUM_W + 2 * BLK_CNT_W + CNT_W;

   if (FRAME_LEN < 2 || FRAME_LEN > 65535 || 64'(FRAME_LEN) >= (64'd1 << CNT_W)
       || FF_DLY < 0) begin : g_param_err
      $error("block_cnt_frame_stats: illegal FRAME_LEN/CNT_W/FF_DLY combination");
   end

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     idx_q, idx_d;
   logic [SUM_W-1:0]     acc_sum_q, acc_sum_d;
   logic [BLK_CNT_W-1:0] acc_max_q, acc_max_d;
   logic [BLK_CNT_W-1:0] acc_min_q, acc_min_d;
   logic [CNT_W-1:0]     acc_zero_q, acc_zero_d;

   logic [SUM_W-1:0]     fold_sum;
   logic [BLK_CNT_W-1:0] fold_max;
   logic [BLK_CNT_W-1:0] fold_min;
   logic [CNT_W-1:0]     fold_zero;
   logic [CNT_W-1:0]     fold_idx;
   logic                 is_zero;
   logic                 last_word;
   logic [PAY_W-1:0]     out_data;

   // fold_* is the frame state with the current word already included, so the
   // final word reaches the output register on the same edge it is accepted.
   always_comb begin
      is_zero = (block_cnt == '0);
      if (state_q == S_IDLE) begin
         fold_sum  = SUM_W'(sat_add(64'd0, block_cnt, SUM_W));
         fold_max  = block_cnt;
         fold_min  = block_cnt;
         fold_zero = CNT_W'(is_zero);
         fold_idx  = CNT_W'(1);
      end else begin
         fold_sum  = SUM_W'(sat_add(64'(acc_sum_q), block_cnt, SUM_W));
         fold_max  = (block_cnt > acc_max_q) ? block_cnt : acc_max_q;
         fold_min  = (block_cnt < acc_min_q) ? block_cnt : acc_min_q;
         fold_zero = acc_zero_q + CNT_W'(is_zero);
         fold_idx  = idx_q + CNT_W'(1);
      end
      last_word = valid && !frame_clr && (state_q == S_ACC)
                  && (idx_q == CNT_W'(FRAME_LEN - 1));

      state_d    = state_q;
      idx_d      = idx_q;
      acc_sum_d  = acc_sum_q;
      acc_max_d  = acc_max_q;
      acc_min_d  = acc_min_q;
      acc_zero_d = acc_zero_q;
      if (frame_clr || last_word) begin
         state_d    = S_IDLE;
         idx_d      = '0;
         acc_sum_d  = '0;
         acc_max_d  = '0;
         acc_min_d  = '0;
         acc_zero_d = '0;
      end else if (valid) begin
         state_d    = S_ACC;
         idx_d      = fold_idx;
         acc_sum_d  = fold_sum;
         acc_max_d  = fold_max;
         acc_min_d  = fold_min;
         acc_zero_d = fold_zero;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         acc_sum_q  <= '0;
         acc_max_q  <= '0;
         acc_min_q  <= '0;
         acc_zero_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_sum_q  <= acc_sum_d;
         acc_max_q  <= acc_max_d;
         acc_min_q  <= acc_min_d;
         acc_zero_q <= acc_zero_d;
      end
   end

   blk_stat_outreg #(
      .W (PAY_W)
   ) u_outreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (last_word),
      .load_data ({fold_sum, fold_max, fold_min, fold_zero}),
      .ovf_clr   (frame_clr),
      .out_data  (out_data),
      .out_valid (frm_valid),
      .out_ready (frm_ready),
      .ovf       (ovf)
   );

   assign {frm_sum, frm_max, frm_min, frm_zero} = out_data;

endmodule

// File: tb/tb_block_cnt_frame_stats.sv
// Directed scoreboard bench for block_cnt_frame_stats (FRAME_LEN=4), plus a narrow-sum
// instance for saturation.
module tb_block_cnt_frame_stats;

   localparam int FL = 4;
   localparam int SW = 12;

   typedef struct packed {
      logic [SW-1:0] sum;
      logic [3:0]    mx;
      logic [3:0]    mn;
      logic [15:0]   zero;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    block_cnt = '0;
   logic          valid = 1'b0;
   logic          frame_clr = 1'b0;
   logic          frm_ready = 1'b1;
   logic [SW-1:0] frm_sum;
   logic [3:0]    frm_max, frm_min;
   logic [15:0]   frm_zero;
   logic          frm_valid, ovf;

   logic [3:0]    s_block_cnt = '0;
   logic          s_valid = 1'b0;
   logic [3:0]    s_frm_sum;
   logic [3:0]    s_frm_max, s_frm_min;
   logic [15:0]   s_frm_zero;
   logic          s_frm_valid, s_ovf;

   res_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_idx = 0, m_sum = 0, m_max = 0, m_min = 0, m_zero = 0;
   bit   m_ovf = 1'b0;

   always #5 clk = ~clk;

   block_cnt_frame_stats #(
      .FF_DLY(1), .FRAME_LEN(FL), .SUM_W(SW), .CNT_W(16)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .block_cnt(block_cnt), .valid(valid),
      .frame_clr(frame_clr), .frm_sum(frm_sum), .frm_max(frm_max), .frm_min(frm_min),
      .frm_zero(frm_zero), .frm_valid(frm_valid), .frm_ready(frm_ready), .ovf(ovf)
   );

   block_cnt_frame_stats #(
      .FF_DLY(1), .FRAME_LEN(FL), .SUM_W(4), .CNT_W(16)
   ) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .block_cnt(s_block_cnt), .valid(s_valid),
      .frame_clr(1'b0), .frm_sum(s_frm_sum), .frm_max(s_frm_max), .frm_min(s_frm_min),
      .frm_zero(s_frm_zero), .frm_valid(s_frm_valid), .frm_ready(1'b1), .ovf(s_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: score any handshake, advance the frame model, then check status.
   task automatic tick();
      res_t r, e;
      bit   hs, pend, done;
      int   bc;
      hs   = (frm_valid === 1'b1) && frm_ready;
      pend = (sbq.size() != 0);
      done = 1'b0;
      bc   = int'(block_cnt);
      if (hs) begin
         chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("hs_sum", 32'(frm_sum), 32'(e.sum));
            chk("hs_max", 32'(frm_max), 32'(e.mx));
            chk("hs_min", 32'(frm_min), 32'(e.mn));
            chk("hs_zero", 32'(frm_zero), 32'(e.zero));
         end
      end
      if (frame_clr) begin
         m_idx = 0;
         m_ovf = 1'b0;
      end else if (valid) begin
         if (m_idx == 0) begin
            m_sum = bc; m_max = bc; m_min = bc; m_zero = (bc == 0) ? 1 : 0;
         end else begin
            m_sum  = (m_sum + bc > 4095) ? 4095 : m_sum + bc;
            m_max  = (bc > m_max) ? bc : m_max;
            m_min  = (bc < m_min) ? bc : m_min;
            m_zero = m_zero + ((bc == 0) ? 1 : 0);
         end
         m_idx++;
         if (m_idx == FL) begin
            m_idx = 0;
            done  = 1'b1;
         end
      end
      if (done) begin
         r.sum  = SW'(m_sum);
         r.mx   = 4'(m_max);
         r.mn   = 4'(m_min);
         r.zero = 16'(m_zero);
         if (!pend || hs) sbq.push_back(r);
         else m_ovf = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("frm_valid", 32'(frm_valid), 32'(sbq.size() != 0));
      chk("ovf", 32'(ovf), 32'(m_ovf));
   endtask

   task automatic word(input logic [3:0] bc);
      valid     = 1'b1;
      block_cnt = bc;
      tick();
      valid     = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_out(input string tag, input int sum, input int mx, input int mn,
                            input int zero);
      chk({tag, "_valid"}, 32'(frm_valid), 32'd1);
      chk({tag, "_sum"}, 32'(frm_sum), 32'(sum));
      chk({tag, "_max"}, 32'(frm_max), 32'(mx));
      chk({tag, "_min"}, 32'(frm_min), 32'(mn));
      chk({tag, "_zero"}, 32'(frm_zero), 32'(zero));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, 32'(frm_valid), 32'd0);
      chk({tag, "_sum"}, 32'(frm_sum), 32'd0);
      chk({tag, "_max"}, 32'(frm_max), 32'd0);
      chk({tag, "_min"}, 32'(frm_min), 32'd0);
      chk({tag, "_zero"}, 32'(frm_zero), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf), 32'd0);
   endtask

   initial begin
      #2;
      check_reset_outputs("rst");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1: back-to-back frame, result one clock after the last word
      frm_ready = 1'b1;
      word(4'd3); word(4'd0); word(4'd5);
      chk("t1_no_early", 32'(frm_valid), 32'd0);
      word(4'd1);
      check_out("t1", 9, 5, 0, 1);
      idle(1);
      chk("t1_drop", 32'(frm_valid), 32'd0);

      // 2: gapped words
      for (int i = 0; i < FL; i++) begin
         word(4'd2);
         if (i < FL - 1) begin
            idle(3);
            chk("t2_no_early", 32'(frm_valid), 32'd0);
         end
      end
      check_out("t2", 8, 2, 2, 0);
      idle(1);

      // 3: stalled consumer drops the second frame
      frm_ready = 1'b0;
      repeat (FL) word(4'd1);
      repeat (FL) word(4'd7);
      check_out("t3", 4, 1, 1, 0);
      chk("t3_ovf", 32'(ovf), 32'd1);
      frm_ready = 1'b1;
      idle(1);
      chk("t3_drained", 32'(frm_valid), 32'd0);

      // 4: completion coincides with handshake
      frame_clr = 1'b1;
      tick();
      frame_clr = 1'b0;
      chk("t4_ovf_clr", 32'(ovf), 32'd0);
      frm_ready = 1'b0;
      word(4'd1); word(4'd2); word(4'd3); word(4'd4);
      word(4'd0); word(4'd6); word(4'd0);
      frm_ready = 1'b1;
      word(4'd2);
      check_out("t4", 8, 6, 0, 2);
      chk("t4_ovf", 32'(ovf), 32'd0);
      idle(1);

      // 5: saturation on the narrow-sum instance
      s_valid     = 1'b1;
      s_block_cnt = 4'd15;
      idle(FL);
      s_valid = 1'b0;
      chk("t5_valid", 32'(s_frm_valid), 32'd1);
      chk("t5_sum", 32'(s_frm_sum), 32'd15);
      chk("t5_max", 32'(s_frm_max), 32'd15);
      chk("t5_min", 32'(s_frm_min), 32'd15);
      chk("t5_zero", 32'(s_frm_zero), 32'd0);

      // 6: frame_clr discards the partial frame and its same-cycle word
      word(4'd5); word(4'd6);
      frame_clr = 1'b1;
      word(4'd9);
      frame_clr = 1'b0;
      repeat (FL) word(4'd1);
      check_out("t6", 4, 1, 1, 0);
      idle(1);

      // 6b: reset mid-frame with a held result
      frm_ready = 1'b0;
      repeat (FL) word(4'd5);
      word(4'd3); word(4'd3);
      rst_n = 1'b0;
      #2;
      check_reset_outputs("t6_rst");
      sbq.delete();
      m_idx = 0;
      m_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);
      frm_ready = 1'b1;
      repeat (FL) word(4'd3);
      check_out("t6_clean", 12, 3, 3, 0);
      idle(2);
      chk("sb_empty", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
